// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-to-voice allocator with retrigger, free-voice and oldest-voice stealing.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   note_valid/ready    event handshake (ready only while idle)
//   note_on, note_fcw   event type and carrier FCW naming the note
//   all_off             panic: release every voice, drop any in-flight event
//   carrier_fcws        per-voice carrier FCW, voice v at [24v+23:24v]
//   note_en             per-voice enable
//   alloc_voice         voice touched by the last committed event
//   steal, miss         one-cycle pulses after a commit
module voice_allocator #(
  parameter int N_VOICES = 4,
  parameter int STAMP_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic                          note_on,
  input  logic [23:0]                   note_fcw,
  input  logic                          all_off,
  output logic [24*N_VOICES-1:0]        carrier_fcws,
  output logic [N_VOICES-1:0]           note_en,
  output logic [$clog2(N_VOICES)-1:0]   alloc_voice,
  output logic                          steal,
  output logic                          miss
);
  localparam int IW = $clog2(N_VOICES);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t               state;
  logic [IW-1:0]        idx;
  logic                 lat_on;
  logic [23:0]          lat_fcw;
  logic [STAMP_W-1:0]   stamp [N_VOICES];
  logic [STAMP_W-1:0]   seq;
  logic                 hit_f, free_f, old_f;
  logic [IW-1:0]        hit_i, free_i, old_i;
  logic [STAMP_W-1:0]   old_age;
  logic                 cur_en, cur_hit;
  logic [STAMP_W-1:0]   cur_age;
  logic [IW-1:0]        tgt;
  assign cur_en  = note_en[idx];
  assign cur_hit = cur_en && carrier_fcws[24*idx +: 24] == lat_fcw;
  // modular age keeps oldest-voice selection correct across seq wrap
  assign cur_age = seq - stamp[idx];
  assign tgt     = hit_f ? hit_i : free_f ? free_i : old_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      note_ready   <= 1'b0;
      carrier_fcws <= '0;
      note_en      <= '0;
      alloc_voice  <= '0;
      steal        <= 1'b0;
      miss         <= 1'b0;
      seq          <= '0;
      idx          <= '0;
      lat_on       <= 1'b0;
      lat_fcw      <= '0;
      hit_f        <= 1'b0;
      free_f       <= 1'b0;
      old_f        <= 1'b0;
      hit_i        <= '0;
      free_i       <= '0;
      old_i        <= '0;
      old_age      <= '0;
      for (int v = 0; v < N_VOICES; v++) stamp[v] <= '0;
    end else if (all_off) begin
      state      <= IDLE;
      note_ready <= 1'b1;
      note_en    <= '0;
      steal      <= 1'b0;
      miss       <= 1'b0;
    end else begin
      steal <= 1'b0;
      miss  <= 1'b0;
      case (state)
        IDLE: begin
          note_ready <= 1'b1;
          if (note_valid && note_ready) begin
            lat_on     <= note_on;
            lat_fcw    <= note_fcw;
            idx        <= '0;
            hit_f      <= 1'b0;
            free_f     <= 1'b0;
            old_f      <= 1'b0;
            note_ready <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          // first hit / first free win; strictly older replaces so ties keep the lowest index
          if (cur_hit && !hit_f) begin
            hit_f <= 1'b1;
            hit_i <= idx;
          end
          if (!cur_en && !free_f) begin
            free_f <= 1'b1;
            free_i <= idx;
          end
          if (cur_en && (!old_f || cur_age > old_age)) begin
            old_f   <= 1'b1;
            old_i   <= idx;
            old_age <= cur_age;
          end
          if (idx == IW'(N_VOICES - 1)) state <= COMMIT;
          else idx <= idx + 1'b1;
        end
        COMMIT: begin
          state      <= IDLE;
          note_ready <= 1'b1;
          if (lat_on) begin
            carrier_fcws[24*tgt +: 24] <= lat_fcw;
            note_en[tgt]               <= 1'b1;
            stamp[tgt]                 <= seq;
            seq                        <= seq + 1'b1;
            alloc_voice                <= tgt;
            steal                      <= !hit_f && !free_f;
          end else if (hit_f) begin
            note_en[hit_i] <= 1'b0;
            alloc_voice    <= hit_i;
          end else begin
            miss <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
